htif_responder: RTL
===================

Name: htif_responder

Overview:
- Memory-mapped host-interface responder on the core's data bus.
- Answers the core's stores and loads to the TOHOST and FROMHOST words.
- Decodes the riscv-tests completion protocol into sticky done, pass and fail-number outputs, plus a cycle watchdog.
- Replaces register-peeking in the per-test benches: a bench only waits for done and then writes the result file.

Parameters:
- TOHOST_ADDR, 32'h80001000, word address of the tohost register.
- FROMHOST_ADDR, 32'h80001040, word address of the fromhost register.
- TIMEOUT_CYCLES, 5000, cycles spent in RUN before TIMEOUT is declared.
- CNT_W, 32, width of the watchdog and cycle counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  bus request valid.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_wdata  in  32  store data.
- req_wstrb  in  4  byte enables for stores.
- resp_valid  out  1  response valid.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  32  load data; 0 for stores.
- resp_err  out  1  address miss.
- done  out  1  a terminal state has been reached.
- pass  out  1  the test passed.
- fail_num  out  31  failing test number (tohost>>1).
- timeout  out  1  the watchdog expired.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN; tohost=0, fromhost=0, watchdog=0.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - done=0, pass=0, fail_num=0, timeout=0.
- Handshake:
  - A request is accepted when req_valid & req_ready.
  - resp_valid rises on the next cycle and holds, with stable data, until resp_ready.
  - req_ready = !resp_valid | resp_ready, so one request may be outstanding.
  - Back-to-back requests complete at one per cycle when resp_ready is held high.
- Decode: compare req_addr[31:2] against TOHOST_ADDR[31:2] and FROMHOST_ADDR[31:2].
  - Miss: store ignored, rdata=0, err=1.
  - A hit on either word returns its current value for a load.
- Stores: per-byte merge under req_wstrb; a strobe of 0 is an accepted no-op.
- Tohost decode, applied to the merged value v once the write has been applied:
  - v==0: no action.
  - v==1: PASS.
  - v odd and >1: FAIL, with fail_num=v[31:1].
  - v even and nonzero: syscall. State stays RUN and fromhost is written to 1 on the following cycle.
- Fromhost: writable by the core. A core write and the syscall auto-ack in the same cycle resolve to the auto-ack value.
- States: RUN, PASS, FAIL, TIMEOUT.
  - The watchdog increments every cycle in RUN.
  - When watchdog==TIMEOUT_CYCLES-1 and no terminal tohost write is accepted that cycle, go to TIMEOUT.
  - A tohost write accepted in the same cycle as the watchdog expiring wins.
- Terminal states are sticky until reset.
  - Further requests are still accepted and answered, and the registers still update.
  - done, pass, fail_num and timeout never change again.
  - The watchdog freezes.
- Outputs in terminal states: done=1 in all three; pass=1 only in PASS; timeout=1 only in TIMEOUT.
- Reset asserted mid-transaction: the pending response is dropped, and resp_valid falls asynchronously.

Optional Feature:
- Macro: HTIF_CYCLE_CNT_EN.
- Defined:
  - A free-running CNT_W cycle counter starts at 0 on reset release.
  - Its value is captured on the cycle the terminal state is entered.
  - The captured value appears on extra output port cycle_count [CNT_W-1:0].
  - It is readable by a load at TOHOST_ADDR+8; stores there are ignored with err=0.
- Undefined: no port, no counter, and TOHOST_ADDR+8 decodes as a miss.

Test Plan:
- Store 32'h1 to 32'h80001000 with wstrb=4'hF → next cycle resp_valid=1, err=0; done=1, pass=1, fail_num=0, timeout=0.
- Store 32'h7 to tohost → done=1, pass=0, fail_num=3. A later store of 32'h1 leaves pass=0 and fail_num=3.
- Store 32'h2 to tohost → state stays RUN. A load of 32'h80001040 two cycles later returns 32'h1, and a load of tohost returns 32'h2.
- No stores, TIMEOUT_CYCLES=20 → done=1 and timeout=1 exactly 20 cycles after reset release. A tohost store of 32'h1 accepted in that 20th cycle gives pass=1 and timeout=0 instead.
- Load 32'h80002000 → rdata=0, err=1. Hold resp_ready=0 for 3 cycles: resp_valid and its data stay stable, req_ready=0 throughout, and a new request is accepted in the same cycle resp_ready rises.
- Pull rst low while a response is pending → resp_valid=0 and done=0 immediately. After release, store 32'h5 → fail_num=2.

Source files
------------

// File: rtl/htif_responder_if.sv
// Data-bus interface between the core and the htif_responder.
// The core drives requests through "master".
// The responder answers them through "slave".
interface htif_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/htif_responder.sv
// htif_responder: memory-mapped TOHOST/FROMHOST responder with riscv-tests
// completion decoding and a RUN-state watchdog.
// Optional build macro HTIF_CYCLE_CNT_EN adds a free-running cycle counter.
// The counter value is captured when a terminal state is entered, driven on
// cycle_count, and readable at TOHOST_ADDR+8.
module htif_responder #(
    parameter logic [31:0] TOHOST_ADDR    = 32'h80001000,
    parameter logic [31:0] FROMHOST_ADDR  = 32'h80001040,
    parameter int          TIMEOUT_CYCLES = 5000,
    parameter int          CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active-low
    htif_responder_if.slave   bus,
    output logic              done,
    output logic              pass,
    output logic [30:0]       fail_num,
    output logic              timeout
`ifdef HTIF_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0]  cycle_count
`endif
);

    typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_t;

    localparam logic [29:0]      TOHOST_W   = TOHOST_ADDR[31:2];
    localparam logic [29:0]      FROMHOST_W = FROMHOST_ADDR[31:2];
    localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  watchdog_q;
    logic              done_q, pass_q, timeout_q;
    logic [30:0]       fail_num_q;
    logic [31:0]       tohost_q, fromhost_q;
    logic              ack_pending_q;
    logic              resp_valid_q, resp_err_q;
    logic [31:0]       resp_rdata_q;

    logic        accept;
    logic        hit_to, hit_fr, hit_any;
    logic        to_wr, fr_wr;
    logic [31:0] to_merged, fr_merged;
    logic        in_run, wr_pass, wr_fail, wr_sys, wd_expire, enter_term;
    logic [31:0] rdata_d;
    logic        err_d;

    // Address bits [1:0] are deliberately ignored by the word decode.
    logic unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, bus.req_addr[1:0]};

    assign bus.req_ready  = !resp_valid_q | bus.resp_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    assign done     = done_q;
    assign pass     = pass_q;
    assign fail_num = fail_num_q;
    assign timeout  = timeout_q;

    assign accept = bus.req_valid & bus.req_ready;
    assign hit_to = (bus.req_addr[31:2] == TOHOST_W);
    assign hit_fr = (bus.req_addr[31:2] == FROMHOST_W);

`ifdef HTIF_CYCLE_CNT_EN
    logic [CNT_W-1:0] cyc_q, cyc_cap_q;
    logic             hit_cc;
    assign hit_cc      = (bus.req_addr[31:2] == TOHOST_W + 30'd2);
    assign hit_any     = hit_to | hit_fr | hit_cc;
    assign cycle_count = cyc_cap_q;
`else
    assign hit_any = hit_to | hit_fr;
`endif

    // Byte-lane merge of store data into the current register contents.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign to_merged[8*gi +: 8] = bus.req_wstrb[gi] ? bus.req_wdata[8*gi +: 8]
                                                            : tohost_q[8*gi +: 8];
            assign fr_merged[8*gi +: 8] = bus.req_wstrb[gi] ? bus.req_wdata[8*gi +: 8]
                                                            : fromhost_q[8*gi +: 8];
        end
    endgenerate

    assign to_wr = accept & bus.req_we & hit_to;
    assign fr_wr = accept & bus.req_we & hit_fr;

    // Completion protocol decode of the merged tohost value; only acted on in RUN.
    assign in_run     = (state_q == ST_RUN);
    assign wr_pass    = in_run & to_wr & (to_merged == 32'd1);
    assign wr_fail    = in_run & to_wr & to_merged[0] & (to_merged != 32'd1);
    assign wr_sys     = in_run & to_wr & ~to_merged[0] & (to_merged != 32'd0);
    assign wd_expire  = in_run & (watchdog_q == WD_LAST);
    assign enter_term = wr_pass | wr_fail | wd_expire;

    // Load data / miss flag for the request being accepted this cycle.
    always_comb begin
        rdata_d = 32'd0;
        err_d   = !hit_any;
        if (!bus.req_we) begin
            if (hit_to)      rdata_d = tohost_q;
            else if (hit_fr) rdata_d = fromhost_q;
`ifdef HTIF_CYCLE_CNT_EN
            else if (hit_cc) rdata_d = 32'(cyc_cap_q);
`endif
        end
    end

    // Response register: load on accept, hold until the core takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else if (accept) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= rdata_d;
            resp_err_q   <= err_d;
        end else if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    // Host registers; a syscall auto-ack overrides a same-cycle core write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tohost_q      <= 32'd0;
            fromhost_q    <= 32'd0;
            ack_pending_q <= 1'b0;
        end else begin
            if (to_wr) tohost_q <= to_merged;
            if (ack_pending_q)  fromhost_q <= 32'd1;
            else if (fr_wr)     fromhost_q <= fr_merged;
            ack_pending_q <= wr_sys;
        end
    end

    // Completion FSM with registered status flags; terminal states are sticky.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            watchdog_q <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            fail_num_q <= 31'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (wr_pass) begin
                        state_q <= ST_PASS;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b1;
                    end else if (wr_fail) begin
                        state_q    <= ST_FAIL;
                        done_q     <= 1'b1;
                        fail_num_q <= to_merged[31:1];
                    end else if (wd_expire) begin
                        state_q   <= ST_TIMEOUT;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        watchdog_q <= watchdog_q + 1'b1;
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

`ifdef HTIF_CYCLE_CNT_EN
    // Free-running cycle counter, snapshotted on entry to a terminal state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q     <= '0;
            cyc_cap_q <= '0;
        end else begin
            cyc_q <= cyc_q + 1'b1;
            if (enter_term) cyc_cap_q <= cyc_q;
        end
    end
`endif

endmodule
